// File: rtl/ex_div_pkg.sv
// -----------------------------------------------------------------------------
// ex_div_pkg
// Shared definitions for the EX-stage multi-cycle divider: FSM state
// encoding, result/start levels, word constants and the operand-magnitude
// helper used when a division is accepted.
// -----------------------------------------------------------------------------
package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic        DIV_RESULT_READY     = 1'b1;
  localparam logic        DIV_RESULT_NOT_READY = 1'b0;
  localparam logic        DIV_START            = 1'b1;
  localparam logic        DIV_STOP             = 1'b0;
  localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;

  // Number of restoring iterations, one per quotient bit.
  localparam logic [5:0]  DIV_STEPS            = 6'd32;

  // Magnitude of an operand: two's complement only for a negative value of a
  // signed division; DIVU operands are taken as-is.
  function automatic logic [31:0] magnitude(input logic [31:0] value,
                                            input logic        is_signed);
    return (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

  function automatic logic [31:0] negate_if(input logic [31:0] value,
                                            input logic        negate);
    return negate ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/ex_div_unit.sv
// -----------------------------------------------------------------------------
// ex_div_unit
// Multi-cycle 32-bit restoring divider for DIV/DIVU in the EX stage. While a
// division is in flight it raises the EX stall request; on completion it
// presents {remainder, quotient} for HI/LO writeback and holds it until EX
// drops start_i.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   start_i       in   division request, held until ready_o is seen
//   annul_i       in   cancel current/pending division
//   signed_div_i  in   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     in   dividend, sampled on the accept edge only
//   opdata2_i     in   divisor, sampled on the accept edge only
//   result_o      out  [63:32] remainder (HI), [31:0] quotient (LO)
//   ready_o       out  result valid
//   stall_req_o   out  combinational stall request towards the pipeline
// -----------------------------------------------------------------------------
module ex_div_unit
  import ex_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_req_o
);

  div_state_e  state, state_d;
  logic [5:0]  cnt, cnt_d;
  // {partial remainder, dividend/quotient}; bit 0 receives the next quotient
  // bit, so the upper 33 bits [64:32] always hold the already-shifted
  // partial remainder that the trial subtraction works on.
  logic [64:0] work, work_d;
  logic [31:0] divisor, divisor_d;
  logic        neg_quot, neg_quot_d;
  logic        neg_rem, neg_rem_d;
  logic [63:0] result_d;
  logic        ready_d;

  logic [32:0] trial;
  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;

  // A set bit 32 means the shifted partial remainder was smaller than the
  // divisor, i.e. the restoring step must discard the difference.
  assign trial       = work[64:32] - {1'b0, divisor};
  assign stall_req_o = start_i & ~ready_o & ~annul_i;

  // Quotient sign follows XOR of operand signs, remainder follows dividend.
  assign quot_fixed  = negate_if(work[31:0],  neg_quot);
  assign rem_fixed   = negate_if(work[64:33], neg_rem);

  // NOTE: every always_comb output gets its hold value first, so no path
  // through the case statement can leave a variable unassigned (no latch).
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    work_d     = work;
    divisor_d  = divisor;
    neg_quot_d = neg_quot;
    neg_rem_d  = neg_rem;
    result_d   = result_o;
    ready_d    = ready_o;

    if (state != DIV_FREE && annul_i) begin
      // Cancellation beats every other transition; nothing partial escapes.
      state_d  = DIV_FREE;
      cnt_d    = '0;
      result_d = {ZERO_WORD, ZERO_WORD};
      ready_d  = DIV_RESULT_NOT_READY;
    end else begin
      unique case (state)
        DIV_FREE: begin
          result_d = {ZERO_WORD, ZERO_WORD};
          ready_d  = DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && !annul_i) begin
            divisor_d  = magnitude(opdata2_i, signed_div_i);
            work_d     = {ZERO_WORD, magnitude(opdata1_i, signed_div_i), 1'b0};
            neg_quot_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_d  = signed_div_i & opdata1_i[31];
            cnt_d      = '0;
            state_d    = (opdata2_i == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
          end
        end

        DIV_BY_ZERO: begin
          result_d = {ZERO_WORD, ZERO_WORD};
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
        end

        DIV_ON: begin
          if (cnt == DIV_STEPS) begin
            result_d = {rem_fixed, quot_fixed};
            ready_d  = DIV_RESULT_READY;
            state_d  = DIV_END;
          end else begin
            work_d = trial[32] ? {work[63:0], 1'b0}
                               : {trial[31:0], work[31:0], 1'b1};
            cnt_d  = cnt + 6'd1;
          end
        end

        DIV_END: begin
          if (start_i == DIV_STOP) begin
            result_d = {ZERO_WORD, ZERO_WORD};
            ready_d  = DIV_RESULT_NOT_READY;
            state_d  = DIV_FREE;
          end
        end

        default: state_d = DIV_FREE;
      endcase
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= ZERO_WORD;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= {ZERO_WORD, ZERO_WORD};
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      work     <= work_d;
      divisor  <= divisor_d;
      neg_quot <= neg_quot_d;
      neg_rem  <= neg_rem_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// -----------------------------------------------------------------------------
// tb_ex_div_unit
// Directed bench for ex_div_unit. An arithmetic reference (native / and %)
// plus a cycle-budget latency rule give the expected outputs; a negedge
// compare process checks ready_o, stall_req_o and result_o every cycle, and
// each directed case also pins its result and latency to hand-computed
// literals.
// -----------------------------------------------------------------------------
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_req_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state for the transaction in flight.
  bit          active = 1'b0;
  int          start_cyc = 0;
  int          exp_lat = 0;
  logic [63:0] exp_res = '0;

  ex_div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stall_req_o  (stall_req_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Architectural result: quotient truncates toward zero, remainder carries
  // the dividend's sign, divide-by-zero yields zero, INT_MIN / -1 wraps.
  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        sgn);
    int sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  // Per-cycle compare: result becomes visible exp_lat cycles after start was
  // first raised and stays until the transaction is retired by the driver.
  always @(negedge clk) begin
    logic er;
    er = active && ((cyc - start_cyc) >= exp_lat);
    check("ready_o", {63'h0, ready_o}, {63'h0, er});
    check("stall_req_o", {63'h0, stall_req_o}, {63'h0, start_i & ~er & ~annul_i});
    check("result_o", result_o, er ? exp_res : 64'h0);
  end

  task automatic begin_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic sgn);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    exp_res      = model(a, b, sgn);
    exp_lat      = (b == 32'h0) ? 2 : 34;
    start_cyc    = cyc;
    active       = 1'b1;
    start_i      = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the edge on which the
  // divider is back in its idle state.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, output logic [63:0] got,
                         output int lat);
    begin_txn(a, b, sgn);
    lat = -1;
    got = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) begin
        lat = cyc - start_cyc;
        got = result_o;
        break;
      end
      if (i == 3) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: ready_o got 0 expected 1 within 40 cycles");
    end
    @(posedge clk);
    #1 start_i = 1'b0;
    @(posedge clk);
    #1 active = 1'b0;
  endtask

  task automatic do_case(input string name, input logic [31:0] a,
                         input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp_literal, input int lat_literal);
    logic [63:0] got;
    int          lat;
    run_div(a, b, sgn, got, lat);
    check({name, "_result"}, got, exp_literal);
    check({name, "_latency"}, 64'(lat), 64'(lat_literal));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation got no finish expected finish");
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b1;
    #6;
    check("reset_ready", {63'h0, ready_o}, 64'h0);
    check("reset_result", result_o, 64'h0);
    check("reset_stall", {63'h0, stall_req_o}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    do_case("u100_7",    32'd100,       32'd7,         1'b0, {32'd2, 32'd14},              34);
    do_case("s-7_2",     32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    do_case("s7_-2",     32'd7,         32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 34);
    do_case("s_div0",    32'd5,         32'd0,         1'b1, 64'h0,                         2);
    do_case("u_div0",    32'hFFFF_FFFF, 32'd0,         1'b0, 64'h0,                         2);
    do_case("s_ovf",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000},         34);
    do_case("u_max_1",   32'hFFFF_FFFF, 32'd1,         1'b0, {32'h0, 32'hFFFF_FFFF},         34);
    do_case("u_bigrem",  32'hFFFF_FFFF, 32'h8000_0001, 1'b0, {32'h7FFF_FFFE, 32'h1},         34);
    do_case("s-100_-7",  32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 34);
    do_case("u_hex",     32'h1234_5678, 32'h1234,      1'b0, {32'h0000_0DA8, 32'h0001_0004}, 34);

    // Annul in cycle C+10: stall drops that cycle, idle on the next edge.
    begin_txn(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1 annul_i = 1'b1;
    #1 check("annul_stall", {63'h0, stall_req_o}, 64'h0);
    @(posedge clk);
    #1 annul_i = 1'b0;
    start_i = 1'b0;
    active  = 1'b0;
    check("annul_ready", {63'h0, ready_o}, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    do_case("after_annul", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34);

    // Reset in cycle C+20 clears outputs without waiting for an edge.
    begin_txn(32'd100, 32'd7, 1'b0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    start_i = 1'b0;
    active  = 1'b0;
    #1;
    check("midrst_ready", {63'h0, ready_o}, 64'h0);
    check("midrst_result", result_o, 64'h0);
    check("midrst_stall", {63'h0, stall_req_o}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    do_case("after_rst", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
